// File: rtl/polar_to_rect_pkg.sv
// Shared constants for the polar_to_rect CORDIC rotator: arctangent table,
// gain compensation factor and binary-angle format constants.
package polar_to_rect_pkg;

    localparam int ITER_MAX = 14;
    localparam int K_Q10    = 622;

    localparam logic [15:0] ANG_PI      = 16'd32768;
    localparam logic [15:0] ANG_HALF_PI = 16'd16384;

    // round(atan(2^-i) * 32768 / pi), binary-angle units
    localparam logic [15:0] ATAN [ITER_MAX] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163,
        16'd81,   16'd41,   16'd20,   16'd10,   16'd5,   16'd3,   16'd1
    };

endpackage

// File: rtl/polar_to_rect_rot_stage.sv
// One registered CORDIC micro-rotation (rotation mode): steers z toward zero
// by +/-ATAN[STAGE] while rotating (x, y) by the matching shift-add step.
module cordic_rot_stage
    import polar_to_rect_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int IW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 val_i,
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [15:0]   z_i,
    output logic                 val_o,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic signed [15:0]   z_o
);

    localparam logic signed [15:0] ANGLE = signed'(ATAN[STAGE]);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    assign x_sh = x_i >>> STAGE;
    assign y_sh = y_i >>> STAGE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_o <= 1'b0;
            x_o   <= '0;
            y_o   <= '0;
            z_o   <= '0;
        end else begin
            val_o <= val_i;
            if (!z_i[15]) begin
                x_o <= x_i - y_sh;
                y_o <= y_i + x_sh;
                z_o <= z_i - ANGLE;
            end else begin
                x_o <= x_i + y_sh;
                y_o <= y_i - x_sh;
                z_o <= z_i + ANGLE;
            end
        end
    end

endmodule

// File: rtl/polar_to_rect.sv
// Pipelined CORDIC polar-to-rectangular converter (magnitude/binary angle -> I/Q).
// Define POLAR_TO_RECT_SAT_EN for a symmetric [-127,127] output clamp; otherwise outputs wrap.
module polar_to_rect
    import polar_to_rect_pkg::*;
#(
    parameter int ITER = 12,
    parameter int IW   = 16,
    parameter int FRAC = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              val_i,
    input  logic [7:0]        abs_i,
    input  logic [15:0]       angle_i,
    output logic              val_o,
    output logic signed [7:0] real_o,
    output logic signed [7:0] imag_o
);

    // Valid-only stream, no ready: a sample is taken on every clk edge with
    // val_i=1, and val_o marks each result exactly ITER+3 cycles later.

    localparam logic signed [IW+10:0] K_GAIN   = (IW+11)'(K_Q10);
    localparam logic signed [IW-1:0]  RND_HALF = IW'(1 << (FRAC - 1));

    logic signed [IW-1:0] xs [0:ITER];
    logic signed [IW-1:0] ys [0:ITER];
    logic signed [15:0]   zs [0:ITER];
    logic                 vs [0:ITER];

    // Pre-rotation folds |angle| >= pi/2 into the CORDIC convergence range.
    logic              half_turn;
    logic [IW-1:0]     mag_ext;
    logic signed [IW-1:0] x_p;
    logic signed [15:0]   z_p;
    logic                 v_p;

    assign half_turn = angle_i[15] ^ angle_i[14];
    assign mag_ext   = IW'(abs_i) << FRAC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_p <= 1'b0;
            x_p <= '0;
            z_p <= '0;
        end else begin
            v_p <= val_i;
            x_p <= half_turn ? -signed'(mag_ext) : signed'(mag_ext);
            z_p <= half_turn ? signed'(angle_i + ANG_PI) : signed'(angle_i);
        end
    end

    assign xs[0] = x_p;
    assign ys[0] = '0;
    assign zs[0] = z_p;
    assign vs[0] = v_p;

    for (genvar k = 0; k < ITER; k++) begin : g_stage
        cordic_rot_stage #(.STAGE(k), .IW(IW)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .val_i (vs[k]),
            .x_i   (xs[k]),
            .y_i   (ys[k]),
            .z_i   (zs[k]),
            .val_o (vs[k+1]),
            .x_o   (xs[k+1]),
            .y_o   (ys[k+1]),
            .z_o   (zs[k+1])
        );
    end

    // Gain compensation: multiply by 1/K ~= 622/1024.
    logic signed [IW+10:0] x_ext, y_ext, x_prod, y_prod;
    logic signed [IW-1:0]  x_g, y_g;
    logic                  v_g;

    assign x_ext  = {{11{xs[ITER][IW-1]}}, xs[ITER]};
    assign y_ext  = {{11{ys[ITER][IW-1]}}, ys[ITER]};
    assign x_prod = x_ext * K_GAIN;
    assign y_prod = y_ext * K_GAIN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_g <= 1'b0;
            x_g <= '0;
            y_g <= '0;
        end else begin
            v_g <= vs[ITER];
            x_g <= IW'(x_prod >>> 10);
            y_g <= IW'(y_prod >>> 10);
        end
    end

    logic signed [IW-1:0] x_rnd, y_rnd;
    logic signed [7:0]    re_lim, im_lim;

    assign x_rnd = (x_g + RND_HALF) >>> FRAC;
    assign y_rnd = (y_g + RND_HALF) >>> FRAC;

    always_comb begin
        re_lim = x_rnd[7:0];
        im_lim = y_rnd[7:0];
`ifdef POLAR_TO_RECT_SAT_EN
        if (x_rnd > IW'(127))       re_lim = 8'sd127;
        else if (x_rnd < -IW'(127)) re_lim = -8'sd127;
        if (y_rnd > IW'(127))       im_lim = 8'sd127;
        else if (y_rnd < -IW'(127)) im_lim = -8'sd127;
`endif
    end

    logic unused_bits;
`ifdef POLAR_TO_RECT_SAT_EN
    assign unused_bits = ^zs[ITER];
`else
    assign unused_bits = ^{zs[ITER], x_rnd[IW-1:8], y_rnd[IW-1:8]};
`endif

    // Only the output register is gated so results hold across gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_o  <= 1'b0;
            real_o <= '0;
            imag_o <= '0;
        end else begin
            val_o <= v_g;
            if (v_g) begin
                real_o <= re_lim;
                imag_o <= im_lim;
            end
        end
    end

endmodule

// File: doc/polar_to_rect.md
# polar_to_rect

Pipelined CORDIC rotator converting a magnitude/phase pair back into signed rectangular components (real, imag). It is the inverse of the abs/angle extraction path:
- consumes the same 8-bit magnitude and 16-bit binary-angle formats;
- produces the 8-bit I/Q format used at that path's input.

It is fully pipelined, accepts one sample per clock and has no backpressure.

## Interface
- ITER, 12: CORDIC micro-rotation stages, 8..14.
- IW, 16: signed internal x/y datapath width.
- FRAC, 6: fractional bits appended to abs_i on entry.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- val_i  in  1  input sample valid.
- abs_i  in  8  unsigned magnitude, 0..255.
- angle_i  in  16  signed binary angle, 2^16 = 2π (−32768 = −π, 16384 = +π/2).
- val_o  out  1  output sample valid.
- real_o  out  8  signed, ≈ abs·cos(angle).
- imag_o  out  8  signed, ≈ abs·sin(angle).

## Operation
- **Reset:**
  - While rst is high, all stage valid bits and all data registers are 0; val_o, real_o and imag_o read 0.
  - Reset is asynchronous: val_o falls immediately.
  - In-flight samples are discarded; nothing is emitted for them after release.
- **Stage P (pre-rotation), registered:**
  - x0 = abs_i·2^FRAC, y0 = 0, z0 = angle_i.
  - If angle_i[15]^angle_i[14] (|θ| ≥ π/2): x0 = −abs_i·2^FRAC and z0 = angle_i + 32768 (mod 2^16).
  - After this step z0 lies in [−16384, 16383].
- **Stages 0..ITER−1 (micro-rotations), each registered:**
  - d = +1 if z ≥ 0, else −1.
  - x' = x − d·(y>>>i).
  - y' = y + d·(x>>>i).
  - z' = z − d·ATAN[i], with ATAN[i] = round(atan(2^−i)·32768/π), so ATAN[0] = 8192.
  - Shifts are arithmetic; no intermediate saturation is needed (max |x|,|y| ≈ 255·64·1.647 < 2^15).
- **Stage G (gain compensation), registered:** x, y multiplied by K_Q10 = 622, then >>>10.
- **Stage R (output), registered:**
  - Round half-up: add 2^(FRAC−1), then >>>FRAC.
  - Limit to 8 bits (see Configuration).
  - Loads real_o/imag_o only when the stage valid bit is set; otherwise the outputs hold the last valid result.
- **Valid:**
  - val_i shifts through a per-stage valid bit.
  - Data stages run free; only stage R is gated.
- **Accuracy:** |real_o − round(abs·cos θ)| ≤ 1 and likewise for imag_o, for ITER = 12 and all in-range results.
- z residual is not output.

## Timing
- Latency L = ITER + 3 cycles from val_i sampled high to val_o high (15 for defaults).
- Throughput: one sample per clock.
  - Back-to-back val_i yields back-to-back val_o in order.
  - Gaps in val_i are preserved exactly.
- First sample after rst deassertion: val_o is high L cycles after the first accepted val_i.
  - No val_o pulse occurs earlier, even if val_i was high during reset.

## Configuration
- `POLAR_TO_RECT_SAT_EN`:
  - **Defined:** stage R clamps to [−127, +127].
    - Symmetric clamp; −128 is never produced.
    - E.g. abs = 200, θ = 0 gives real_o = 127.
  - **Undefined:** stage R truncates to the low 8 bits (two's-complement wrap).
    - E.g. abs = 200, θ = 0 gives real_o = −56 (0xC8).
    - This saves the comparators; use it only when upstream guarantees abs ≤ 127.

## Structure
- Package polar_to_rect_pkg holds:
  - ATAN table constant (14 entries, 16-bit);
  - K_Q10 = 622;
  - ITER_MAX = 14;
  - the angle-format constants ANG_PI = 32768 and ANG_HALF_PI = 16384.
- One sub-module, cordic_rot_stage:
  - Parameterised by the stage index i and IW.
  - Contains registers for x, y, z and valid, with async reset.
  - The top instantiates ITER copies via generate.
  - Pre-rotation, gain and output stages live in the top.

## Test plan
- **Cardinal angles:** abs = 100 with θ = 0, 16384, −32768, −16384 -> (real, imag) = (100, 0), (0, 100), (−100, 0), (0, −100), each ±1, with val_o L = 15 cycles after val_i.
- **Diagonal and zero:**
  - abs = 127, θ = 8192 -> (90, 90) ±1.
  - abs = 0, any θ -> (0, 0).
- **Saturation, SAT_EN defined:**
  - abs = 255, θ = 0 -> (127, 0).
  - abs = 255, θ = −32768 -> (−127, 0).
- **Wrap, SAT_EN undefined:** abs = 200, θ = 0 -> real_o = −56.
- **Streaming:**
  - 64 consecutive val_i samples with θ stepping by 1024 and abs = 100, then a 3-cycle gap, then 4 more.
  - Outputs arrive in order, within ±1 of the reference model, and with an identical gap pattern.
  - real_o/imag_o hold their values during the gap.
- **Reset mid-stream:**
  - Assert rst for 2 cycles while 10 samples are in flight.
  - val_o drops at once and the outputs read 0.
  - None of the 10 samples ever appears.
  - The next sample after release emerges exactly L cycles after its val_i.
